// File: rtl/aes_bridge_pkg.sv
// Shared types and helpers for the Wishbone-to-dmem bridge in front of the AES block.
package aes_bridge_pkg;

    // Bridge sequencing states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RESP = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4,
        WAIT = 3'd5
    } state_t;

    // dmem response codes (any value with bit 1 set is an error)
    localparam logic [1:0] RESP_NONE = 2'b00;
    localparam logic [1:0] RESP_OK   = 2'b01;

    // dmem access widths
    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;

    // Decoded byte-select: access width, byte offset, and whether the pattern is unusable
    typedef struct packed {
        logic       illegal;
        logic [1:0] width;
        logic [1:0] offset;
    } sel_dec_t;

    // Map a Wishbone byte-lane select onto a naturally aligned dmem access
    function automatic sel_dec_t sel_to_width_ofs(input logic [3:0] sel);
        sel_dec_t d;
        d.illegal = 1'b0;
        d.width   = W_BYTE;
        d.offset  = 2'b00;
        case (sel)
            4'b0001: begin d.width = W_BYTE; d.offset = 2'b00; end
            4'b0010: begin d.width = W_BYTE; d.offset = 2'b01; end
            4'b0100: begin d.width = W_BYTE; d.offset = 2'b10; end
            4'b1000: begin d.width = W_BYTE; d.offset = 2'b11; end
            4'b0011: begin d.width = W_HALF; d.offset = 2'b00; end
            4'b1100: begin d.width = W_HALF; d.offset = 2'b10; end
            4'b1111: begin d.width = W_WORD; d.offset = 2'b00; end
            default: begin d.illegal = 1'b1; end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/aes_wb_bridge.sv
// Wishbone-classic slave that serialises single transactions onto the AES dmem port.
// Every output comes straight from a flop; the FSM and timeout counter live here.
module aes_wb_bridge #(
    parameter int   TO_CYCLES = 64,
    parameter logic PORT_ID   = 1'b0
) (
    input  logic        mclk,
    input  logic        rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [6:0]  wbs_adr_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        dmem_req,
    output logic        dmem_cmd,
    output logic [1:0]  dmem_width,
    output logic [6:0]  dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_req_ack,
    input  logic [31:0] dmem_rdata,
    input  logic [1:0]  dmem_resp
);
    import aes_bridge_pkg::*;

    localparam int             CW      = $clog2(TO_CYCLES);
    localparam logic [CW-1:0]  TO_LAST = CW'(TO_CYCLES - 1);

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_abort;
    logic           r_req;
    logic           r_cmd;
    logic [1:0]     r_width;
    logic [6:0]     r_addr;
    logic [31:0]    r_wdata;
    logic [31:0]    r_dat;
    logic           r_ack;
    logic           r_err;

    state_t         w_state_nxt;
    logic [CW-1:0]  w_cnt_nxt;
    logic           w_abort_nxt;
    logic           w_req_nxt;
    logic           w_cmd_nxt;
    logic [1:0]     w_width_nxt;
    logic [6:0]     w_addr_nxt;
    logic [31:0]    w_wdata_nxt;
    logic [31:0]    w_dat_nxt;
    logic           w_ack_nxt;
    logic           w_err_nxt;

    sel_dec_t       w_dec;
    logic           w_abort_now;
    logic           w_resp_ok;
    logic           w_resp_err;
    logic           w_timeout;
    logic           w_unused;

    assign w_dec       = sel_to_width_ofs(wbs_sel_i);
    // Once the master walks away mid-transaction, finish the dmem side silently.
    assign w_abort_now = r_abort | ~wbs_cyc_i;
    assign w_resp_ok   = (dmem_resp == RESP_OK);
    assign w_resp_err  = dmem_resp[1];
    assign w_timeout   = (r_cnt == TO_LAST);
    assign w_unused    = ^{wbs_adr_i[6], wbs_adr_i[1:0]};

    // Next-state and next-register-value logic for the transaction sequencer
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_abort_nxt = r_abort;
        w_req_nxt   = r_req;
        w_cmd_nxt   = r_cmd;
        w_width_nxt = r_width;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_dat_nxt   = r_dat;
        w_ack_nxt   = (r_state == DONE);
        w_err_nxt   = (r_state == ERR);

        case (r_state)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    if (w_dec.illegal) begin
                        w_state_nxt = ERR;
                    end else begin
                        w_cmd_nxt   = wbs_we_i;
                        w_width_nxt = w_dec.width;
                        w_addr_nxt  = {PORT_ID, wbs_adr_i[5:2], w_dec.offset};
                        w_wdata_nxt = wbs_dat_i;
                        w_req_nxt   = 1'b1;
                        w_cnt_nxt   = '0;
                        w_abort_nxt = 1'b0;
                        w_state_nxt = REQ;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end

            REQ: begin
                w_abort_nxt = w_abort_now;
                if (dmem_req_ack) begin
                    w_req_nxt = 1'b0;
                    w_cnt_nxt = '0;
                    if (w_resp_ok) begin
                        if (!r_cmd && !w_abort_now) begin
                            w_dat_nxt = dmem_rdata;
                        end else begin
                            w_dat_nxt = r_dat;
                        end
                        w_state_nxt = w_abort_now ? WAIT : DONE;
                    end else if (w_resp_err) begin
                        w_state_nxt = w_abort_now ? WAIT : ERR;
                    end else begin
                        w_state_nxt = RESP;
                    end
                end else if (w_timeout) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = w_abort_now ? WAIT : ERR;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            RESP: begin
                w_abort_nxt = w_abort_now;
                if (w_resp_ok) begin
                    if (!r_cmd && !w_abort_now) begin
                        w_dat_nxt = dmem_rdata;
                    end else begin
                        w_dat_nxt = r_dat;
                    end
                    w_state_nxt = w_abort_now ? WAIT : DONE;
                end else if (w_resp_err) begin
                    w_state_nxt = w_abort_now ? WAIT : ERR;
                end else if (w_timeout) begin
                    w_state_nxt = w_abort_now ? WAIT : ERR;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end

            DONE: begin
                w_state_nxt = WAIT;
            end

            ERR: begin
                w_state_nxt = WAIT;
            end

            WAIT: begin
                // A strobe still held from the finished cycle must not start a new one.
                if (!wbs_stb_i) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WAIT;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_abort <= 1'b0;
            r_req   <= 1'b0;
            r_cmd   <= 1'b0;
            r_width <= 2'b00;
            r_addr  <= 7'd0;
            r_wdata <= 32'd0;
            r_dat   <= 32'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_abort <= w_abort_nxt;
            r_req   <= w_req_nxt;
            r_cmd   <= w_cmd_nxt;
            r_width <= w_width_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_dat   <= w_dat_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign wbs_dat_o  = r_dat;
    assign wbs_ack_o  = r_ack;
    assign wbs_err_o  = r_err;
    assign dmem_req   = r_req;
    assign dmem_cmd   = r_cmd;
    assign dmem_width = r_width;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;

endmodule
